// File: rtl/io_bus_fabric_pkg.sv
// Shared types and helpers for the I/O bus fabric: FSM states, bus widths and
// the lowest-index-wins port selector.
package io_fabric_pkg;

  localparam int IO_DATA_W    = 16;
  localparam int IO_ADDR_W    = 15;
  localparam int IO_MAX_PORTS = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    MISS = 2'd2,
    DONE = 2'd3
  } io_state_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } hit_sel_t;

  // Scan from the top down so the lowest set bit is the one left standing.
  function automatic hit_sel_t first_hit(input logic [IO_MAX_PORTS-1:0] hit);
    hit_sel_t r;
    r.valid = 1'b0;
    r.idx   = '0;
    for (int i = IO_MAX_PORTS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        r.valid = 1'b1;
        r.idx   = 4'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/io_bus_fabric_if.sv
// Host-side and device-side signals of the I/O fabric. The slave modport is
// the fabric's view; the master modport is the host plus attached devices.
interface io_bus_if #(parameter int NUM_PORTS = 8);
  import io_fabric_pkg::*;

  logic                           h_access;
  logic [IO_ADDR_W-1:0]           h_addr;
  logic                           h_wr_en;
  logic [1:0]                     h_bytesel;
  logic [IO_DATA_W-1:0]           h_wdata;
  logic [IO_DATA_W-1:0]           h_rdata;
  logic                           h_ack;

  logic [NUM_PORTS-1:0]           d_cs;
  logic [IO_ADDR_W-1:0]           d_addr;
  logic                           d_wr_en;
  logic [1:0]                     d_bytesel;
  logic [IO_DATA_W-1:0]           d_wdata;
  logic [NUM_PORTS-1:0]           d_ack;
  logic [NUM_PORTS*IO_DATA_W-1:0] d_rdata;

  modport slave (
    input  h_access, h_addr, h_wr_en, h_bytesel, h_wdata, d_ack, d_rdata,
    output h_rdata, h_ack, d_cs, d_addr, d_wr_en, d_bytesel, d_wdata
  );

  modport master (
    output h_access, h_addr, h_wr_en, h_bytesel, h_wdata, d_ack, d_rdata,
    input  h_rdata, h_ack, d_cs, d_addr, d_wr_en, d_bytesel, d_wdata
  );

endinterface

// File: rtl/io_addr_match.sv
// Single base/mask port comparator; address bit 0 is not part of the port space.
module io_addr_match
  import io_fabric_pkg::*;
#(
  parameter logic [15:0] BASE = 16'h0000,
  parameter logic [15:0] MASK = 16'hFFFE
) (
  input  logic [IO_ADDR_W-1:0] addr,
  output logic                 hit
);

  assign hit = ((addr & MASK[15:1]) == (BASE[15:1] & MASK[15:1]));

endmodule

// File: rtl/io_bus_fabric.sv
// Registered I/O-space decoder and response mux with single-outstanding FSM.
// Optional watchdog enabled by defining IO_FABRIC_TIMEOUT_EN.
module io_bus_fabric
  import io_fabric_pkg::*;
#(
  parameter int                        NUM_PORTS      = 8,
  parameter logic [NUM_PORTS*16-1:0]   PORT_BASE      = {NUM_PORTS{16'h0000}},
  parameter logic [NUM_PORTS*16-1:0]   PORT_MASK      = {NUM_PORTS{16'hFFFE}},
  parameter logic [IO_DATA_W-1:0]      DEFAULT_RDATA  = 16'h0000,
  parameter int                        TIMEOUT_CYCLES = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  io_bus_if.slave              bus,
  input  logic                 err_clr,
  output logic                 err_timeout,
  output logic [IO_ADDR_W-1:0] err_addr
);

  logic [NUM_PORTS-1:0]    hit;
  logic [IO_MAX_PORTS-1:0] hit_ext;
  hit_sel_t                win;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_match
    io_addr_match #(
      .BASE (PORT_BASE[g*16 +: 16]),
      .MASK (PORT_MASK[g*16 +: 16])
    ) u_match (
      .addr (bus.h_addr),
      .hit  (hit[g])
    );
  end

  assign hit_ext = IO_MAX_PORTS'(hit);
  assign win     = first_hit(hit_ext);

  io_state_e            state_q, state_d;
  logic [3:0]           sel_q, sel_d;
  logic [NUM_PORTS-1:0] d_cs_q, d_cs_d;
  logic [IO_ADDR_W-1:0] d_addr_q, d_addr_d;
  logic                 d_wr_en_q, d_wr_en_d;
  logic [1:0]           d_bytesel_q, d_bytesel_d;
  logic [IO_DATA_W-1:0] d_wdata_q, d_wdata_d;
  logic [IO_DATA_W-1:0] h_rdata_q, h_rdata_d;
  logic                 h_ack_q, h_ack_d;
  logic [IO_DATA_W-1:0] rdata_sel;
  logic                 ack_sel;
  logic                 wd_expire;

  always_comb begin
    rdata_sel = '0;
    ack_sel   = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (sel_q == 4'(i)) begin
        rdata_sel = bus.d_rdata[i*IO_DATA_W +: IO_DATA_W];
        ack_sel   = bus.d_ack[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    d_cs_d      = d_cs_q;
    d_addr_d    = d_addr_q;
    d_wr_en_d   = d_wr_en_q;
    d_bytesel_d = d_bytesel_q;
    d_wdata_d   = d_wdata_q;
    h_rdata_d   = h_rdata_q;
    h_ack_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.h_access) begin
          d_addr_d    = bus.h_addr;
          d_wr_en_d   = bus.h_wr_en;
          d_bytesel_d = bus.h_bytesel;
          d_wdata_d   = bus.h_wdata;
          sel_d       = win.idx;
          if (win.valid) begin
            state_d = BUSY;
            for (int i = 0; i < NUM_PORTS; i++) d_cs_d[i] = (win.idx == 4'(i));
          end else begin
            state_d = MISS;
          end
        end
      end
      BUSY: begin
        // A real ack in the expiry cycle takes priority over the watchdog.
        if (ack_sel) begin
          h_rdata_d = rdata_sel;
          d_cs_d    = '0;
          h_ack_d   = 1'b1;
          state_d   = DONE;
        end else if (wd_expire) begin
          h_rdata_d = DEFAULT_RDATA;
          d_cs_d    = '0;
          h_ack_d   = 1'b1;
          state_d   = DONE;
        end
      end
      MISS: begin
        h_rdata_d = DEFAULT_RDATA;
        h_ack_d   = 1'b1;
        state_d   = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      d_cs_q      <= '0;
      d_addr_q    <= '0;
      d_wr_en_q   <= 1'b0;
      d_bytesel_q <= '0;
      d_wdata_q   <= '0;
      h_rdata_q   <= '0;
      h_ack_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      d_cs_q      <= d_cs_d;
      d_addr_q    <= d_addr_d;
      d_wr_en_q   <= d_wr_en_d;
      d_bytesel_q <= d_bytesel_d;
      d_wdata_q   <= d_wdata_d;
      h_rdata_q   <= h_rdata_d;
      h_ack_q     <= h_ack_d;
    end
  end

`ifdef IO_FABRIC_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0]     wd_cnt_q, wd_cnt_d;
  logic                 err_timeout_q, err_timeout_d;
  logic [IO_ADDR_W-1:0] err_addr_q, err_addr_d;

  assign wd_expire = (state_q == BUSY) && (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wd_cnt_d      = (state_q == BUSY) ? wd_cnt_q + 1'b1 : '0;
    err_timeout_d = err_timeout_q;
    err_addr_d    = err_addr_q;
    if (err_clr) err_timeout_d = 1'b0;
    if (wd_expire && !ack_sel) begin
      err_timeout_d = 1'b1;
      if (!err_timeout_q) err_addr_d = d_addr_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt_q      <= '0;
      err_timeout_q <= 1'b0;
      err_addr_q    <= '0;
    end else begin
      wd_cnt_q      <= wd_cnt_d;
      err_timeout_q <= err_timeout_d;
      err_addr_q    <= err_addr_d;
    end
  end

  assign err_timeout = err_timeout_q;
  assign err_addr    = err_addr_q;
`else
  logic unused_err_clr;

  assign wd_expire      = 1'b0;
  assign err_timeout    = 1'b0;
  assign err_addr       = '0;
  assign unused_err_clr = err_clr;
`endif

  assign bus.d_cs      = d_cs_q;
  assign bus.d_addr    = d_addr_q;
  assign bus.d_wr_en   = d_wr_en_q;
  assign bus.d_bytesel = d_bytesel_q;
  assign bus.d_wdata   = d_wdata_q;
  assign bus.h_rdata   = h_rdata_q;
  assign bus.h_ack     = h_ack_q;

endmodule

// File: tb/tb_io_bus_fabric.sv
// Directed bench for io_bus_fabric: 4 ports, port0 0xFFF8/0xFFF8, port1 0x0100,
// port2 0x0040/0xFFFC, port3 0xFFFE; watchdog scenario depends on IO_FABRIC_TIMEOUT_EN.
module tb_io_bus_fabric;
  import io_fabric_pkg::*;

  localparam int          NP  = 4;
  localparam logic [15:0] DEF = 16'hDEAD;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 err_clr = 1'b0;
  logic                 err_timeout;
  logic [IO_ADDR_W-1:0] err_addr;
  int                   n_cmp = 0;
  int                   n_err = 0;

  io_bus_if #(.NUM_PORTS(NP)) bus ();

  io_bus_fabric #(
    .NUM_PORTS      (NP),
    .PORT_BASE      ({16'hFFFE, 16'h0040, 16'h0100, 16'hFFF8}),
    .PORT_MASK      ({16'hFFFE, 16'hFFFC, 16'hFFFE, 16'hFFF8}),
    .DEFAULT_RDATA  (DEF),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .err_clr     (err_clr),
    .err_timeout (err_timeout),
    .err_addr    (err_addr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_cmp++;
    if ({bus.h_rdata, bus.h_ack, bus.d_cs} !== {16'h0, 1'b0, 4'h0}) begin
      n_err++;
      $display("FAIL reset_host: got rdata/ack/cs %h/%b/%b exp 0/0/0", bus.h_rdata, bus.h_ack, bus.d_cs);
    end
    n_cmp++;
    if ({bus.d_addr, bus.d_wr_en, bus.d_bytesel, bus.d_wdata, err_timeout, err_addr} !== '0) begin
      n_err++;
      $display("FAIL reset_dev: got addr %h we %b bs %b wd %h et %b ea %h exp all 0",
               bus.d_addr, bus.d_wr_en, bus.d_bytesel, bus.d_wdata, err_timeout, err_addr);
    end
    #3 reset = 1'b0;
    tick();
  endtask

  task automatic test_read();
    bus.d_rdata  = {16'h3333, 16'hBEEF, 16'h2222, 16'h1111};
    bus.h_addr   = 15'h0021;
    bus.h_wr_en  = 1'b0;
    bus.h_access = 1'b1;
    tick();
    n_cmp++;
    if ({bus.d_cs, bus.h_ack, bus.d_addr, bus.d_wr_en} !== {4'b0100, 1'b0, 15'h0021, 1'b0}) begin
      n_err++;
      $display("FAIL read_c1: got cs %b ack %b addr %h we %b exp 0100 0 0021 0",
               bus.d_cs, bus.h_ack, bus.d_addr, bus.d_wr_en);
    end
    tick();
    n_cmp++;
    if ({bus.d_cs, bus.h_ack} !== {4'b0100, 1'b0}) begin
      n_err++;
      $display("FAIL read_c2: got cs %b ack %b exp 0100 0", bus.d_cs, bus.h_ack);
    end
    bus.d_ack = 4'b0100;
    tick();
    bus.d_ack = 4'b0000;
    n_cmp++;
    if ({bus.d_cs, bus.h_ack, bus.h_rdata} !== {4'b0000, 1'b1, 16'hBEEF}) begin
      n_err++;
      $display("FAIL read_c3: got cs %b ack %b rdata %h exp 0000 1 beef", bus.d_cs, bus.h_ack, bus.h_rdata);
    end
    bus.h_access = 1'b0;
    tick();
    n_cmp++;
    if ({bus.d_cs, bus.h_ack, bus.h_rdata} !== {4'b0000, 1'b0, 16'hBEEF}) begin
      n_err++;
      $display("FAIL read_c4: got cs %b ack %b rdata %h exp 0000 0 beef", bus.d_cs, bus.h_ack, bus.h_rdata);
    end
  endtask

  task automatic test_unmapped();
    bus.h_addr   = 15'h091A;
    bus.h_access = 1'b1;
    tick();
    n_cmp++;
    if ({bus.d_cs, bus.h_ack} !== {4'b0000, 1'b0}) begin
      n_err++;
      $display("FAIL miss_c1: got cs %b ack %b exp 0000 0", bus.d_cs, bus.h_ack);
    end
    tick();
    n_cmp++;
    if ({bus.d_cs, bus.h_ack, bus.h_rdata} !== {4'b0000, 1'b1, DEF}) begin
      n_err++;
      $display("FAIL miss_c2: got cs %b ack %b rdata %h exp 0000 1 dead", bus.d_cs, bus.h_ack, bus.h_rdata);
    end
    bus.h_access = 1'b0;
    tick();
    n_cmp++;
    if (bus.h_ack !== 1'b0) begin
      n_err++;
      $display("FAIL miss_c3: got ack %b exp 0", bus.h_ack);
    end
  endtask

  task automatic test_overlap();
    bus.d_rdata  = {16'h3333, 16'hBEEF, 16'h2222, 16'h0A0A};
    bus.h_addr   = 15'h7FFF;
    bus.h_access = 1'b1;
    tick();
    n_cmp++;
    if (bus.d_cs !== 4'b0001) begin
      n_err++;
      $display("FAIL overlap_cs: got %b exp 0001", bus.d_cs);
    end
    bus.d_ack = 4'b1000;
    tick();
    n_cmp++;
    if ({bus.d_cs, bus.h_ack} !== {4'b0001, 1'b0}) begin
      n_err++;
      $display("FAIL overlap_stray: got cs %b ack %b exp 0001 0", bus.d_cs, bus.h_ack);
    end
    bus.d_ack = 4'b0001;
    tick();
    bus.d_ack = 4'b0000;
    n_cmp++;
    if ({bus.h_ack, bus.h_rdata} !== {1'b1, 16'h0A0A}) begin
      n_err++;
      $display("FAIL overlap_done: got ack %b rdata %h exp 1 0a0a", bus.h_ack, bus.h_rdata);
    end
    bus.h_access = 1'b0;
    tick();
  endtask

  task automatic test_write_hold();
    bus.d_rdata   = {16'h3333, 16'hBEEF, 16'h2222, 16'h5A5A};
    bus.h_addr    = 15'h7FFD;
    bus.h_wr_en   = 1'b1;
    bus.h_bytesel = 2'b01;
    bus.h_wdata   = 16'h00A5;
    bus.h_access  = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      n_cmp++;
      if ({bus.d_cs, bus.d_wr_en, bus.d_bytesel, bus.d_wdata, bus.d_addr} !==
          {4'b0001, 1'b1, 2'b01, 16'h00A5, 15'h7FFD}) begin
        n_err++;
        $display("FAIL write_c%0d: got cs %b we %b bs %b wd %h addr %h exp 0001 1 01 00a5 7ffd",
                 c, bus.d_cs, bus.d_wr_en, bus.d_bytesel, bus.d_wdata, bus.d_addr);
      end
    end
    bus.d_ack = 4'b0001;
    tick();
    bus.d_ack = 4'b0000;
    n_cmp++;
    if ({bus.d_cs, bus.h_ack, bus.h_rdata} !== {4'b0000, 1'b1, 16'h5A5A}) begin
      n_err++;
      $display("FAIL write_done: got cs %b ack %b rdata %h exp 0000 1 5a5a", bus.d_cs, bus.h_ack, bus.h_rdata);
    end
    tick();
    n_cmp++;
    if ({bus.d_cs, bus.h_ack} !== {4'b0000, 1'b0}) begin
      n_err++;
      $display("FAIL write_no_dup: got cs %b ack %b exp 0000 0", bus.d_cs, bus.h_ack);
    end
    bus.h_access = 1'b0;
    bus.h_wr_en  = 1'b0;
    tick();
    n_cmp++;
    if (bus.d_cs !== 4'b0000) begin
      n_err++;
      $display("FAIL write_idle: got cs %b exp 0000", bus.d_cs);
    end
  endtask

  task automatic test_back_to_back();
    bus.d_rdata  = {16'h3333, 16'hBEEF, 16'h1357, 16'h5A5A};
    bus.h_addr   = 15'h0080;
    bus.h_access = 1'b1;
    tick();
    bus.d_ack = 4'b0010;
    tick();
    bus.d_ack = 4'b0000;
    n_cmp++;
    if ({bus.d_cs, bus.h_ack, bus.h_rdata} !== {4'b0000, 1'b1, 16'h1357}) begin
      n_err++;
      $display("FAIL b2b_first: got cs %b ack %b rdata %h exp 0000 1 1357", bus.d_cs, bus.h_ack, bus.h_rdata);
    end
    tick();
    n_cmp++;
    if ({bus.d_cs, bus.h_ack} !== {4'b0000, 1'b0}) begin
      n_err++;
      $display("FAIL b2b_idle: got cs %b ack %b exp 0000 0", bus.d_cs, bus.h_ack);
    end
    tick();
    n_cmp++;
    if (bus.d_cs !== 4'b0010) begin
      n_err++;
      $display("FAIL b2b_second_cs: got %b exp 0010", bus.d_cs);
    end
    bus.d_ack = 4'b0010;
    tick();
    bus.d_ack    = 4'b0000;
    bus.h_access = 1'b0;
    n_cmp++;
    if (bus.h_ack !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_second_ack: got %b exp 1", bus.h_ack);
    end
    tick();
  endtask

  task automatic test_timeout();
    bus.h_addr   = 15'h0021;
    bus.h_access = 1'b1;
`ifdef IO_FABRIC_TIMEOUT_EN
    for (int c = 1; c <= 8; c++) begin
      tick();
      n_cmp++;
      if ({bus.d_cs, bus.h_ack} !== {4'b0100, 1'b0}) begin
        n_err++;
        $display("FAIL wd_cs_c%0d: got cs %b ack %b exp 0100 0", c, bus.d_cs, bus.h_ack);
      end
    end
    tick();
    n_cmp++;
    if ({bus.d_cs, bus.h_ack, bus.h_rdata, err_timeout, err_addr} !==
        {4'b0000, 1'b1, DEF, 1'b1, 15'h0021}) begin
      n_err++;
      $display("FAIL wd_expire: got cs %b ack %b rdata %h et %b ea %h exp 0000 1 dead 1 0021",
               bus.d_cs, bus.h_ack, bus.h_rdata, err_timeout, err_addr);
    end
    bus.h_access = 1'b0;
    tick();
    n_cmp++;
    if (err_timeout !== 1'b1) begin
      n_err++;
      $display("FAIL wd_sticky: got %b exp 1", err_timeout);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_cmp++;
    if (err_timeout !== 1'b0) begin
      n_err++;
      $display("FAIL wd_clr: got %b exp 0", err_timeout);
    end
`else
    for (int c = 1; c <= 12; c++) tick();
    n_cmp++;
    if ({bus.d_cs, bus.h_ack, err_timeout, err_addr} !== {4'b0100, 1'b0, 1'b0, 15'h0}) begin
      n_err++;
      $display("FAIL nowd_hold: got cs %b ack %b et %b ea %h exp 0100 0 0 0000",
               bus.d_cs, bus.h_ack, err_timeout, err_addr);
    end
    err_clr   = 1'b1;
    bus.d_ack = 4'b0100;
    tick();
    err_clr      = 1'b0;
    bus.d_ack    = 4'b0000;
    bus.h_access = 1'b0;
    n_cmp++;
    if ({bus.h_ack, bus.h_rdata, err_timeout} !== {1'b1, 16'hBEEF, 1'b0}) begin
      n_err++;
      $display("FAIL nowd_done: got ack %b rdata %h et %b exp 1 beef 0", bus.h_ack, bus.h_rdata, err_timeout);
    end
    tick();
`endif
  endtask

  task automatic test_async_reset();
    bus.h_addr   = 15'h0021;
    bus.h_access = 1'b1;
    tick();
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({bus.d_cs, bus.h_ack, bus.d_addr} !== {4'b0000, 1'b0, 15'h0}) begin
      n_err++;
      $display("FAIL arst_busy: got cs %b ack %b addr %h exp 0000 0 0000", bus.d_cs, bus.h_ack, bus.d_addr);
    end
    #2 reset = 1'b0;
    tick();
    bus.d_ack = 4'b0100;
    tick();
    bus.d_ack = 4'b0000;
    n_cmp++;
    if ({bus.h_ack, bus.h_rdata} !== {1'b1, 16'hBEEF}) begin
      n_err++;
      $display("FAIL arst_recover: got ack %b rdata %h exp 1 beef", bus.h_ack, bus.h_rdata);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({bus.h_ack, bus.h_rdata} !== {1'b0, 16'h0}) begin
      n_err++;
      $display("FAIL arst_done: got ack %b rdata %h exp 0 0000", bus.h_ack, bus.h_rdata);
    end
    bus.h_access = 1'b0;
    #2 reset = 1'b0;
    tick();
  endtask

  initial begin
    bus.h_access  = 1'b0;
    bus.h_addr    = '0;
    bus.h_wr_en   = 1'b0;
    bus.h_bytesel = 2'b00;
    bus.h_wdata   = '0;
    bus.d_ack     = '0;
    bus.d_rdata   = '0;
    test_reset();
    test_read();
    test_unmapped();
    test_overlap();
    test_write_hold();
    test_back_to_back();
    test_timeout();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
